// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write path: screen geometry, field widths,
// sink FSM state type and the {x, y} coordinate unpack helpers.
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 9;
  localparam int COORD_W  = 15;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int FB_WORDS = 19200;
  localparam int ENTRY_W  = COLOUR_W + COORD_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR_WAIT,
    ST_CLEAR
  } sink_state_t;

  // Coordinates are packed {x[7:0], y[6:0]} by every producer.
  function automatic logic [X_W-1:0] coord_x(input logic [COORD_W-1:0] c);
    return c[COORD_W-1:Y_W];
  endfunction

  function automatic logic [Y_W-1:0] coord_y(input logic [COORD_W-1:0] c);
    return c[Y_W-1:0];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO buffering incoming {colour, coordinates} pixel writes.
// Head entry is presented combinationally on rdata; push is ignored when full
// and pop is ignored when empty.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = pixel_pkg::ENTRY_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pixel_sink.sv
// Pixel sink: buffers producer pixel writes, range-checks them and turns them
// into linear framebuffer writes; also fills the whole screen on request.
// Pipeline: FIFO head -> p1 (popped entry) -> fb_* output registers.
// The whole pipe stalls while fb_busy is high, so a busy cycle never produces
// a write in the following cycle.
module pixel_sink #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = pixel_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_pkg::SCREEN_H
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [pixel_pkg::COLOUR_W-1:0]  in_colour,
  input  logic [pixel_pkg::COORD_W-1:0]   in_coordinates,
  input  logic                            clear_req,
  input  logic [pixel_pkg::COLOUR_W-1:0]  clear_colour,
  output logic                            clear_done,
  input  logic                            fb_busy,
  output logic                            fb_we,
  output logic [pixel_pkg::ADDR_W-1:0]    fb_addr,
  output logic [pixel_pkg::COLOUR_W-1:0]  fb_data,
  output logic [$clog2(DEPTH):0]          fifo_level,
  output logic [7:0]                      drop_count
);

  import pixel_pkg::*;

  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int XL_W   = X_W + 1;
  localparam int YL_W   = Y_W + 1;
  localparam logic [XL_W-1:0]   X_LIM   = XL_W'(SCREEN_W);
  localparam logic [YL_W-1:0]   Y_LIM   = YL_W'(SCREEN_H);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Linear address y*160 + x as a shift-add pair; the 160-column stride is
  // fixed by the framebuffer layout. In-range inputs never exceed 19199.
  function automatic logic [ADDR_W-1:0] fb_index(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

  sink_state_t         state;
  sink_state_t         state_nxt;
  logic                push;
  logic                pop;
  logic                clear_start;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;
  logic [COLOUR_W-1:0] head_colour;
  logic [COORD_W-1:0]  head_coord;

  logic                vld_p1;
  logic [COLOUR_W-1:0] colour_p1;
  logic [X_W-1:0]      x_p1;
  logic [Y_W-1:0]      y_p1;
  logic                in_range_p1;

  logic [COLOUR_W-1:0] clr_colour;
  logic [ADDR_W-1:0]   clr_addr;
  logic                clr_step;
  logic                clr_final;
  logic                done_p1;

  assign head_colour = head[ENTRY_W-1:COORD_W];
  assign head_coord  = head[COORD_W-1:0];
  assign in_range_p1 = ({1'b0, x_p1} < X_LIM) && ({1'b0, y_p1} < Y_LIM);
  assign clr_step    = (state == ST_CLEAR) && !fb_busy;
  assign clr_final   = clr_step && (clr_addr == FB_LAST);

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  ({in_colour, in_coordinates}),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Next-state, handshake and pop decisions.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    clear_start = 1'b0;

    if (resetn && !fifo_full && (state == ST_IDLE || state == ST_DRAIN))
      in_ready = 1'b1;
    push = in_valid && in_ready;
    pop  = (state == ST_DRAIN || state == ST_CLEAR_WAIT) && !fifo_empty && !fb_busy;
    clear_start = clear_req && (state == ST_IDLE || state == ST_DRAIN);

    case (state)
      ST_IDLE: begin
        if (clear_start)  state_nxt = ST_CLEAR_WAIT;
        else if (push)    state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (clear_start)
          state_nxt = ST_CLEAR_WAIT;
        else if (pop && !push && (fifo_level == LVL_W'(1)))
          state_nxt = ST_IDLE;
      end
      ST_CLEAR_WAIT: begin
        // Wait for both the FIFO and the p1 stage to be empty.
        if (fifo_empty && !vld_p1) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_final) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // ---- stage p1: popped FIFO entry (valid) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       vld_p1 <= 1'b0;
    else if (!fb_busy) vld_p1 <= pop;
  end

  // Stage p1 payload, captured on pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      colour_p1 <= head_colour;
      x_p1      <= coord_x(head_coord);
      y_p1      <= coord_y(head_coord);
    end
  end

  // Clear colour latched when a clear request is accepted.
  always_ff @(posedge clk) begin
    if (clear_start) clr_colour <= clear_colour;
  end

  // ---- stage p2: framebuffer write port and drop counter ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      drop_count <= '0;
    end else if (fb_busy) begin
      fb_we <= 1'b0;
    end else if (state == ST_CLEAR) begin
      fb_we   <= 1'b1;
      fb_addr <= clr_addr;
      fb_data <= clr_colour;
    end else if (vld_p1 && in_range_p1) begin
      fb_we   <= 1'b1;
      fb_addr <= fb_index(x_p1, y_p1);
      fb_data <= colour_p1;
    end else begin
      fb_we <= 1'b0;
      if (vld_p1) drop_count <= sat_inc(drop_count);
    end
  end

  // Clear address counter and completion pulse one cycle after the last write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_addr   <= '0;
      done_p1    <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      if (state != ST_CLEAR) clr_addr <= '0;
      else if (clr_step)     clr_addr <= clr_addr + 1'b1;
      done_p1    <= clr_final;
      clear_done <= done_p1;
    end
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink: single writes, range boundaries, backpressure,
// screen clear, drop saturation and reset during a clear.
module tb_pixel_sink;

  logic        clk            = 1'b0;
  logic        resetn         = 1'b0;
  logic        in_valid       = 1'b0;
  logic        in_ready;
  logic [8:0]  in_colour      = '0;
  logic [14:0] in_coordinates = '0;
  logic        clear_req      = 1'b0;
  logic [8:0]  clear_colour   = '0;
  logic        clear_done;
  logic        fb_busy        = 1'b0;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;

  int n_chk = 0;
  int n_pass = 0;
  int wq_addr[$];
  int wq_data[$];
  int done_cnt = 0;
  int busy_viol = 0;
  int ready_viol = 0;
  int done_timing_err = 0;
  logic        busy_q = 1'b0;
  logic        in_clear = 1'b0;
  logic        we_prev = 1'b0;
  logic [14:0] addr_prev = '0;

  always #5 clk = ~clk;

  pixel_sink #(.DEPTH(16), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_colour      (in_colour),
    .in_coordinates (in_coordinates),
    .clear_req      (clear_req),
    .clear_colour   (clear_colour),
    .clear_done     (clear_done),
    .fb_busy        (fb_busy),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .fifo_level     (fifo_level),
    .drop_count     (drop_count)
  );

  always @(posedge clk) busy_q <= fb_busy;

  // Write log and protocol watchers, sampled mid-cycle.
  always @(negedge clk) begin
    if (fb_we) begin
      wq_addr.push_back(int'(fb_addr));
      wq_data.push_back(int'(fb_data));
    end
    if (fb_we && busy_q) busy_viol++;
    if (clear_done) begin
      done_cnt++;
      if (fb_we || !we_prev || addr_prev != 15'd19199) done_timing_err++;
    end
    if (in_clear && in_ready && !(fb_we && fb_addr == 15'd19199) && !clear_done)
      ready_viol++;
    we_prev   = fb_we;
    addr_prev = fb_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int qa(input int i);
    if (i < wq_addr.size()) return wq_addr[i];
    return -1;
  endfunction

  function automatic int qd(input int i);
    if (i < wq_data.size()) return wq_data[i];
    return -1;
  endfunction

  // Offer one pixel until accepted (bounded); leaves in_valid high.
  task automatic push_px(input int x, input int y, input int col);
    logic       acc;
    logic [7:0] xb;
    logic [6:0] yb;
    xb = 8'(x);
    yb = 7'(y);
    in_valid       = 1'b1;
    in_coordinates = {xb, yb};
    in_colour      = 9'(col);
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic req_clear(input int col);
    clear_req    = 1'b1;
    clear_colour = 9'(col);
    tick();
    clear_req    = 1'b0;
    clear_colour = '0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_fb_we"},      fb_we, 0);
    chk({pfx, "_fb_addr"},    fb_addr, 0);
    chk({pfx, "_fb_data"},    fb_data, 0);
    chk({pfx, "_clear_done"}, clear_done, 0);
    chk({pfx, "_level"},      fifo_level, 0);
    chk({pfx, "_drop"},       drop_count, 0);
    chk({pfx, "_in_ready"},   in_ready, 0);
  endtask

  initial begin
    int   b;
    int   errs;
    int   d0;
    int   acc_n;
    logic acc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    resetn = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1);

    // Single in-range pixel, 2-cycle latency
    b = wq_addr.size();
    push_px(5, 3, 'h1FF);
    in_valid = 1'b0;
    chk("t1_level", fifo_level, 1);
    chk("t1_we_n0", fb_we, 0);
    tick();
    chk("t1_we_n1", fb_we, 0);
    tick();
    chk("t1_we", fb_we, 1);
    chk("t1_addr", fb_addr, 485);
    chk("t1_data", fb_data, 'h1FF);
    tick();
    chk("t1_we_off", fb_we, 0);
    chk("t1_addr_hold", fb_addr, 485);
    ticks(3);
    chk("t1_nwrites", wq_addr.size() - b, 1);
    chk("t1_drop", drop_count, 0);

    // Range boundaries
    b = wq_addr.size();
    push_px(159, 119, 'h0AA);
    push_px(160, 0, 'h155);
    push_px(0, 120, 'h033);
    in_valid = 1'b0;
    ticks(6);
    chk("t2_nwrites", wq_addr.size() - b, 1);
    chk("t2_addr", qa(b), 19199);
    chk("t2_data", qd(b), 'h0AA);
    chk("t2_drop", drop_count, 2);

    // Backpressure: FIFO fills to 16 under fb_busy
    b = wq_addr.size();
    fb_busy = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid       = 1'b1;
      in_coordinates = {8'(10 + acc_n), 7'd7};
      in_colour      = 9'(acc_n);
      acc = in_ready;
      tick();
      if (acc) acc_n++;
    end
    chk("t3_accepted", acc_n, 16);
    chk("t3_level_full", fifo_level, 16);
    chk("t3_ready_full", in_ready, 0);
    chk("t3_no_writes", wq_addr.size() - b, 0);
    fb_busy = 1'b0;
    for (int c = 0; c < 100 && acc_n < 20; c++) begin
      in_valid       = 1'b1;
      in_coordinates = {8'(10 + acc_n), 7'd7};
      in_colour      = 9'(acc_n);
      acc = in_ready;
      tick();
      if (acc) acc_n++;
    end
    in_valid = 1'b0;
    chk("t3_accepted_all", acc_n, 20);
    ticks(25);
    chk("t3_nwrites", wq_addr.size() - b, 20);
    errs = 0;
    for (int k = 0; k < 20; k++)
      if (qa(b + k) != 1130 + k || qd(b + k) != k) errs++;
    chk("t3_order", errs, 0);
    chk("t3_level_empty", fifo_level, 0);

    // Clear with 3 queued pixels, intermittent fb_busy
    b  = wq_addr.size();
    d0 = done_cnt;
    fb_busy = 1'b1;
    push_px(1, 0, 10);
    push_px(2, 0, 11);
    push_px(3, 0, 12);
    in_valid = 1'b0;
    chk("t4_level", fifo_level, 3);
    req_clear('h049);
    in_clear = 1'b1;
    chk("t4_ready_low", in_ready, 0);
    for (int c = 0; c < 25000 && done_cnt == d0; c++) begin
      fb_busy = ((c % 53) == 7);
      tick();
    end
    fb_busy  = 1'b0;
    in_clear = 1'b0;
    chk("t4_done", done_cnt - d0, 1);
    ticks(5);
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_nwrites", wq_addr.size() - b, 19203);
    errs = 0;
    for (int k = 0; k < 3; k++)
      if (qa(b + k) != 1 + k || qd(b + k) != 10 + k) errs++;
    chk("t4_pixels_first", errs, 0);
    errs = 0;
    for (int k = 0; k < 19200; k++)
      if (qa(b + 3 + k) != k || qd(b + 3 + k) != 'h049) errs++;
    chk("t4_fill_seq", errs, 0);
    chk("t4_done_timing", done_timing_err, 0);
    chk("t4_ready_viol", ready_viol, 0);
    chk("t4_ready_after", in_ready, 1);

    // Drop counter saturation (x=255 and y=127 cases)
    b = wq_addr.size();
    for (int k = 0; k < 100; k++)
      push_px((k % 2) ? 255 : 0, (k % 2) ? 5 : 127, 1);
    in_valid = 1'b0;
    ticks(4);
    chk("t5_drop_102", drop_count, 102);
    for (int k = 0; k < 200; k++)
      push_px(200, 10, 2);
    in_valid = 1'b0;
    ticks(4);
    chk("t5_drop_sat", drop_count, 255);
    chk("t5_nwrites", wq_addr.size() - b, 0);

    // Reset in the middle of a clear
    d0 = done_cnt;
    req_clear('h1C0);
    in_clear = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 6000 && !acc; c++) begin
      tick();
      acc = fb_we && (fb_addr == 15'd5000);
    end
    chk("t6_reach_5000", acc, 1);
    chk("t6_data", fb_data, 'h1C0);
    resetn   = 1'b0;
    in_clear = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    ticks(3);
    chk("t6_no_done", done_cnt - d0, 0);
    resetn = 1'b1;
    tick();
    chk("t6_ready", in_ready, 1);
    b = wq_addr.size();
    push_px(10, 20, 'h123);
    in_valid = 1'b0;
    ticks(4);
    chk("t6_nwrites", wq_addr.size() - b, 1);
    chk("t6_addr", qa(b), 3210);
    chk("t6_data_after", qd(b), 'h123);
    chk("t6_no_done_after", done_cnt - d0, 0);
    chk("busy_gate", busy_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
